// File: rtl/mandelbrot_pkg.sv
// Shared types and widths for the Mandelbrot pixel scheduler and its result FIFO.
package mandelbrot_pkg;

  localparam int COORD_W = 10;
  localparam int ITER_W  = 6;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    ISSUE,
    RELEASE
  } sched_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [ITER_W-1:0]  iter;
    logic               last;
  } result_entry_t;

endpackage

// File: rtl/mandelbrot_pixel_scheduler_if.sv
// Control, engine-link and result-stream signals of the pixel scheduler.
// master is the scheduler's view; slave is the view of the surrounding system.
interface mandelbrot_pixel_scheduler_if;
  import mandelbrot_pkg::*;

  logic               start;
  logic               enable;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               pixel_valid;
  logic               eng_result_valid;
  logic [ITER_W-1:0]  eng_iter;
  logic               eng_busy;
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [ITER_W-1:0]  out_iter;
  logic               out_last;
  logic               active;
  logic               frame_done;

  modport master (
    input  start, enable, eng_result_valid, eng_iter, eng_busy, out_ready,
    output pixel_x, pixel_y, pixel_valid, out_valid, out_x, out_y, out_iter,
           out_last, active, frame_done
  );

  modport slave (
    output start, enable, eng_result_valid, eng_iter, eng_busy, out_ready,
    input  pixel_x, pixel_y, pixel_valid, out_valid, out_x, out_y, out_iter,
           out_last, active, frame_done
  );

endinterface

// File: rtl/mandelbrot_pixel_scheduler_result_fifo.sv
// Small first-word-fall-through FIFO holding engine results for the framebuffer
// writer. The head entry is read straight from registered storage.
module result_fifo
  import mandelbrot_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = result_entry_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  entry_t                   push_data,
  output logic                     full,
  input  logic                     pop,
  output entry_t                   head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_fire;
  logic             pop_fire;

  assign full      = (count == CAP);
  assign empty     = (count == '0);
  assign push_fire = push && !full;
  assign pop_fire  = pop && !empty;
  assign head      = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset along with the pointers so the head entry reads
      // as all-zero out of reset, not whatever the flops powered up with.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_fire) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/mandelbrot_pixel_scheduler.sv
// Raster-scans one frame of pixel coordinates into mandelbrot_engine with a
// single transaction in flight, and queues each result for the framebuffer writer.
module mandelbrot_pixel_scheduler
  import mandelbrot_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int FIFO_DEPTH = 4
) (
  input logic                          clk,
  input logic                          rst_n,
  mandelbrot_pixel_scheduler_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]   FIFO_CAP = CNT_W'(FIFO_DEPTH);
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(V_RES - 1);

  sched_state_t       state;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               frame_done_q;
  logic               at_last;
  logic               engine_quiet;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  result_entry_t      push_entry;
  result_entry_t      head_entry;

  assign at_last      = (x == X_MAX) && (y == Y_MAX);
  assign engine_quiet = !bus.eng_result_valid && !bus.eng_busy;
  assign push         = (state == ISSUE) && bus.eng_result_valid;
  assign pop          = !fifo_empty && bus.out_ready;
  assign push_entry   = '{x: x, y: y, iter: bus.eng_iter, last: at_last};

  // Frame sequencing: arm, issue one pixel, then wait out the engine's
  // lingering result_valid before stepping to the next coordinate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below reads the
      // pre-edge x/y/state regardless of statement order.
      frame_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            x     <= '0;
            y     <= '0;
            state <= ARM;
          end
        end
        ARM: begin
          if (bus.enable && (fifo_count < FIFO_CAP) && engine_quiet) state <= ISSUE;
        end
        ISSUE: begin
          if (bus.eng_result_valid) state <= RELEASE;
        end
        RELEASE: begin
          if (engine_quiet) begin
            if (at_last) begin
              frame_done_q <= 1'b1;
              state        <= IDLE;
            end else begin
              if (x == X_MAX) begin
                x <= '0;
                y <= y + 1'b1;
              end else begin
                x <= x + 1'b1;
              end
              state <= ARM;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  result_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (result_entry_t)
  ) u_result_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .full      (fifo_full),
    .pop       (pop),
    .head      (head_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ARM only issues with a free slot, so a result can never meet a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full))
    else $error("mandelbrot_pixel_scheduler: result pushed into a full FIFO");

  assign bus.pixel_valid = (state == ISSUE);
  assign bus.pixel_x     = x;
  assign bus.pixel_y     = y;
  assign bus.active      = (state != IDLE);
  assign bus.frame_done  = frame_done_q;
  assign bus.out_valid   = !fifo_empty;
  assign bus.out_x       = head_entry.x;
  assign bus.out_y       = head_entry.y;
  assign bus.out_iter    = head_entry.iter;
  assign bus.out_last    = head_entry.last;

endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Scoreboard bench for mandelbrot_pixel_scheduler on a 4x2 frame with an
// engine bus-functional model and a raster-order reference model.
module tb_mandelbrot_pixel_scheduler;

  localparam int H = 4;
  localparam int V = 2;
  localparam int DEPTH = 4;

  typedef struct {
    int x;
    int y;
    int iter;
    bit last;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n;

  mandelbrot_pixel_scheduler_if bus ();

  mandelbrot_pixel_scheduler #(
    .H_RES      (H),
    .V_RES      (V),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  pix_t issue_q[$];
  pix_t exp_q[$];

  int issue_count = 0;
  int rx_count    = 0;
  int fd_count    = 0;
  int cur_salt    = 0;
  int lat_min     = 1;
  int lat_max     = 6;
  int ready_mode  = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one frame is every coordinate in raster order; the engine
  // stand-in answers (x + 4*y + salt) mod 64.
  task automatic model_frame(input int salt);
    for (int yy = 0; yy < V; yy++) begin
      for (int xx = 0; xx < H; xx++) begin
        pix_t p;
        p.x    = xx;
        p.y    = yy;
        p.iter = (xx + 4 * yy + salt) % 64;
        p.last = (xx == H - 1) && (yy == V - 1);
        issue_q.push_back(p);
        exp_q.push_back(p);
      end
    end
  endtask

  // Engine BFM: accepts a request only when enabled and idle, answers after a
  // random latency, holds result_valid two cycles after pixel_valid falls and
  // sometimes keeps busy one cycle longer.
  initial begin : engine_bfm
    int phase, cnt, cx, cy, hold;
    bit extra;
    phase = 0; cnt = 0; cx = 0; cy = 0; hold = 0; extra = 0;
    bus.eng_result_valid = 1'b0;
    bus.eng_busy = 1'b0;
    bus.eng_iter = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        phase = 0;
        bus.eng_result_valid = 1'b0;
        bus.eng_busy = 1'b0;
        bus.eng_iter = '0;
      end else begin
        case (phase)
          0: if (bus.pixel_valid && bus.enable) begin
               bus.eng_busy = 1'b1;
               cnt   = $urandom_range(lat_max, lat_min);
               cx    = int'(bus.pixel_x);
               cy    = int'(bus.pixel_y);
               extra = 1'($urandom_range(1, 0));
               phase = 1;
             end
          1: if (cnt <= 1) begin
               bus.eng_result_valid = 1'b1;
               bus.eng_iter = 6'((cx + 4 * cy + cur_salt) % 64);
               phase = 2;
             end else begin
               cnt--;
             end
          2: if (!bus.pixel_valid) begin
               hold  = 1;
               phase = 3;
             end
          3: if (hold == 0) begin
               bus.eng_result_valid = 1'b0;
               if (extra) phase = 4;
               else begin
                 bus.eng_busy = 1'b0;
                 phase = 0;
               end
             end else begin
               hold--;
             end
          default: begin
            bus.eng_busy = 1'b0;
            phase = 0;
          end
        endcase
      end
    end
  end

  // Downstream ready driver: held low, held high, or random per cycle.
  initial begin : ready_driver
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Monitor: compares issues and popped entries against the model queues.
  initial begin : monitor
    bit prev_pv, prev_active, last_rv, last_busy;
    logic [9:0] stab_x, stab_y;
    pix_t p;
    prev_pv = 0; prev_active = 0; last_rv = 0; last_busy = 0;
    stab_x = '0; stab_y = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pv = 0; prev_active = 0; last_rv = 0; last_busy = 0;
      end else begin
        if (bus.pixel_valid && !prev_pv) begin
          issue_count++;
          if (issue_q.size() == 0) begin
            check("unexpected issue", 32'd1, 32'd0);
          end else begin
            p = issue_q.pop_front();
            check("issue coord", {12'd0, bus.pixel_x, bus.pixel_y},
                  32'((p.x << 10) | p.y));
          end
          check("issue only after engine quiet", {30'd0, last_rv, last_busy}, 32'd0);
          stab_x = bus.pixel_x;
          stab_y = bus.pixel_y;
        end else if (bus.pixel_valid) begin
          check("coord stable in issue", {12'd0, bus.pixel_x, bus.pixel_y},
                {12'd0, stab_x, stab_y});
        end
        if (bus.out_valid && bus.out_ready) begin
          rx_count++;
          if (exp_q.size() == 0) begin
            check("unexpected out entry", 32'd1, 32'd0);
          end else begin
            p = exp_q.pop_front();
            check("out entry", {5'd0, bus.out_x, bus.out_y, bus.out_iter, bus.out_last},
                  32'((p.x << 17) | (p.y << 7) | (p.iter << 1) | int'(p.last)));
          end
        end
        if (bus.frame_done) begin
          fd_count++;
          check("active falls with frame_done", {30'd0, prev_active, bus.active}, 32'd2);
        end
        prev_pv     = bus.pixel_valid;
        prev_active = bus.active;
        last_rv     = bus.eng_result_valid;
        last_busy   = bus.eng_busy;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic start_frame(input int salt);
    cur_salt = salt;
    model_frame(salt);
    pulse_start();
  endtask

  task automatic end_frame(input string tag, input int base_fd, input int base_rx, input int budget);
    int c;
    c = 0;
    while (fd_count == base_fd && c < budget) begin @(negedge clk); c++; end
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin @(negedge clk); c++; end
    cycles(8);
    check({tag, " frame_done pulses"}, 32'(fd_count - base_fd), 32'd1);
    check({tag, " entries received"}, 32'(rx_count - base_rx), 32'(H * V));
    check({tag, " expected queue drained"}, 32'(exp_q.size() + issue_q.size()), 32'd0);
    check({tag, " idle after frame"}, {31'd0, bus.active}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pixel_valid"}, {31'd0, bus.pixel_valid}, 32'd0);
    check({tag, " pixel_x"}, {22'd0, bus.pixel_x}, 32'd0);
    check({tag, " pixel_y"}, {22'd0, bus.pixel_y}, 32'd0);
    check({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, " active"}, {31'd0, bus.active}, 32'd0);
    check({tag, " frame_done"}, {31'd0, bus.frame_done}, 32'd0);
    check({tag, " out_x"}, {22'd0, bus.out_x}, 32'd0);
    check({tag, " out_y"}, {22'd0, bus.out_y}, 32'd0);
    check({tag, " out_iter"}, {26'd0, bus.out_iter}, 32'd0);
    check({tag, " out_last"}, {31'd0, bus.out_last}, 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int bfd, brx, bis, c;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.enable = 1'b1;
    cycles(4);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    cycles(2);

    // Nominal frame, iter = x + 4*y, downstream always ready.
    ready_mode = 1; lat_min = 1; lat_max = 6;
    bfd = fd_count; brx = rx_count;
    start_frame(0);
    end_frame("nominal", bfd, brx, 2000);

    // Backpressure: four transactions fill the FIFO, then ARM holds.
    ready_mode = 0;
    cycles(2);
    bfd = fd_count; brx = rx_count; bis = issue_count;
    start_frame(int'($urandom_range(63, 0)));
    cycles(150);
    check("backpressure issues", 32'(issue_count - bis), 32'(DEPTH));
    check("backpressure pixel_valid low", {31'd0, bus.pixel_valid}, 32'd0);
    check("backpressure still active", {31'd0, bus.active}, 32'd1);
    check("backpressure out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("backpressure no pops", 32'(rx_count - brx), 32'd0);
    ready_mode = 1;
    end_frame("backpressure", bfd, brx, 2000);

    // Long engine latency, random downstream ready, ignored start pulses.
    ready_mode = 2; lat_min = 20; lat_max = 20;
    bfd = fd_count; brx = rx_count;
    start_frame(int'($urandom_range(63, 0)));
    cycles(30);
    pulse_start();
    cycles(45);
    pulse_start();
    end_frame("latency20", bfd, brx, 4000);

    // enable dropped with the third pixel in flight.
    ready_mode = 1; lat_min = 2; lat_max = 8;
    bfd = fd_count; brx = rx_count; bis = issue_count;
    start_frame(int'($urandom_range(63, 0)));
    c = 0;
    while (issue_count - bis < 3 && c < 500) begin @(negedge clk); c++; end
    @(posedge clk); #1 bus.enable = 1'b0;
    cycles(80);
    check("enable low: no new issue", 32'(issue_count - bis), 32'd3);
    check("enable low: in-flight result delivered", 32'(rx_count - brx), 32'd3);
    check("enable low: frame still active", {31'd0, bus.active}, 32'd1);
    @(posedge clk); #1 bus.enable = 1'b1;
    end_frame("enable", bfd, brx, 2000);

    // Asynchronous reset while pixel (2,1) is being issued.
    lat_min = 20; lat_max = 20;
    start_frame(int'($urandom_range(63, 0)));
    c = 0;
    while (!(bus.pixel_valid && bus.pixel_x == 10'd2 && bus.pixel_y == 10'd1) && c < 2000) begin
      @(negedge clk); c++;
    end
    check("reached pixel (2,1)", {31'd0, bus.pixel_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-frame reset");
    issue_q.delete();
    exp_q.delete();
    cycles(3);
    @(posedge clk); #1 rst_n = 1'b1;
    cycles(2);
    check("post-reset out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Fresh frame after reset must restart at (0,0).
    lat_min = 1; lat_max = 4;
    bfd = fd_count; brx = rx_count;
    start_frame(int'($urandom_range(63, 0)));
    end_frame("after reset", bfd, brx, 2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
